// File: rtl/abrutech_bus_pkg.sv
// Shared constants for the Abrutech serial bus: frame field widths, ack pattern
// lengths and the bus master state encoding.
package abrutech_bus_pkg;

  localparam int SID_W        = 3;
  localparam int START_LEN    = 2;
  localparam int ADDR_ACK_LEN = 2;
  localparam int WR_ACK_LEN   = 2;

  localparam int ST_W = 4;
  localparam logic [ST_W-1:0] ST_IDLE          = 4'd0;
  localparam logic [ST_W-1:0] ST_WAIT_GRANT    = 4'd1;
  localparam logic [ST_W-1:0] ST_START         = 4'd2;
  localparam logic [ST_W-1:0] ST_TX_SID        = 4'd3;
  localparam logic [ST_W-1:0] ST_TX_ADDR       = 4'd4;
  localparam logic [ST_W-1:0] ST_WAIT_ADDR_ACK = 4'd5;
  localparam logic [ST_W-1:0] ST_TX_DATA       = 4'd6;
  localparam logic [ST_W-1:0] ST_WAIT_WR_ACK   = 4'd7;
  localparam logic [ST_W-1:0] ST_WAIT_RD_DATA  = 4'd8;
  localparam logic [ST_W-1:0] ST_RX_DATA       = 4'd9;
  localparam logic [ST_W-1:0] ST_DONE          = 4'd10;
  localparam logic [ST_W-1:0] ST_ABORT         = 4'd11;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/master_shift_reg.sv
// Parallel-load shift register: MSB-first serial out, serial in at the LSB,
// and a count of bits shifted since the last load. Single-cycle, no backpressure.
module master_shift_reg #(
  parameter int W     = 18,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_i,
  input  logic [W-1:0]     load_dat_i,
  input  logic             shift_i,
  input  logic             ser_i,
  output logic             ser_o,
  output logic [W-1:0]     par_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [W-1:0]     sr_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      sr_q  <= load_dat_i;
      cnt_q <= '0;
    end else if (shift_i) begin
      sr_q  <= {sr_q[W-2:0], ser_i};
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign ser_o = sr_q[W-1];
  assign par_o = sr_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/bus_master.sv
// Serial bus master: arbitrates, sends start/SID/address header, then writes or reads one word.
// Header takes 5+ADDRESS_WIDTH cycles after grant; slave stalls are bounded by ACK/RD timeouts.
module bus_master
  import abrutech_bus_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 15,
  parameter int DATA_WIDTH    = 8,
  parameter int ACK_TIMEOUT   = 16,
  parameter int RD_TIMEOUT    = 255
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     req_in,
  input  logic                     rd_wrt_in,
  input  logic [SID_W-1:0]         slave_id_in,
  input  logic [ADDRESS_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     arbiter_grant,
  output logic                     bus_req,
  output logic                     bus_util,
  output logic                     rd_wrt,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     done,
  output logic                     error,
  output logic                     busy,
  inout  wire                      data_bus_serial
);

  localparam int HDR_W    = SID_W + ADDRESS_WIDTH;
  localparam int DTX_W    = DATA_WIDTH + 1;
  localparam int SR_W     = max2(HDR_W, DTX_W);
  localparam int SR_CNT_W = $clog2(SR_W + 1);
  localparam int TMO_W    = $clog2(max2(max2(ACK_TIMEOUT, RD_TIMEOUT), START_LEN) + 1);
  localparam int HIST_W   = max2(max2(ADDR_ACK_LEN, WR_ACK_LEN) - 1, 1);

  logic [ST_W-1:0]          state_q, state_d;
  logic [SID_W-1:0]         sid_q, sid_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdat_q, wdat_d;
  logic                     rw_lat_q, rw_lat_d;
  logic                     busy_q, busy_d;
  logic                     bus_req_q, bus_req_d;
  logic                     bus_util_q, bus_util_d;
  logic                     rd_wrt_q, rd_wrt_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic [DATA_WIDTH-1:0]    data_out_q, data_out_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic [HIST_W-1:0]        hist_q, hist_d;

  logic                     bus_s;
  logic                     bus_oe;
  logic                     bus_do;
  logic                     sr_load;
  logic [SR_W-1:0]          sr_load_dat;
  logic                     sr_shift;
  logic                     sr_ser;
  logic [SR_W-1:0]          sr_par;
  logic [SR_CNT_W-1:0]      sr_cnt;
  logic [SR_W-1:0]          hdr_al;
  logic [SR_W-1:0]          dat_al;
  logic [ADDR_ACK_LEN-1:0]  addr_win;
  logic [WR_ACK_LEN-1:0]    wr_win;
  logic                     addr_ack;
  logic                     wr_ack;
  logic                     go_done;
  logic                     go_abort;

  assign bus_s = data_bus_serial;
  assign data_bus_serial = bus_oe ? bus_do : 1'bz;

  // Frames are left-aligned so the shared register always shifts out of its MSB.
  assign hdr_al = SR_W'({sid_q, addr_q}) << (SR_W - HDR_W);
  assign dat_al = SR_W'({1'b1, wdat_q}) << (SR_W - DTX_W);

  // History is preset to ones on wait entry so stale bits can never complete a pattern.
  assign addr_win = ADDR_ACK_LEN'({hist_q, bus_s});
  assign wr_win   = WR_ACK_LEN'({hist_q, bus_s});
  assign addr_ack = (addr_win == '0);
  assign wr_ack   = (wr_win == WR_ACK_LEN'(1));

  master_shift_reg #(
    .W     (SR_W),
    .CNT_W (SR_CNT_W)
  ) u_shift (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (sr_load),
    .load_dat_i (sr_load_dat),
    .shift_i    (sr_shift),
    .ser_i      (bus_s),
    .ser_o      (sr_ser),
    .par_o      (sr_par),
    .cnt_o      (sr_cnt)
  );

  always_comb begin
    bus_oe = 1'b0;
    bus_do = 1'b1;
    case (state_q)
      ST_START: begin
        bus_oe = 1'b1;
        bus_do = 1'b0;
      end
      ST_TX_SID, ST_TX_ADDR, ST_TX_DATA: begin
        bus_oe = 1'b1;
        bus_do = sr_ser;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    sid_d       = sid_q;
    addr_d      = addr_q;
    wdat_d      = wdat_q;
    rw_lat_d    = rw_lat_q;
    busy_d      = busy_q;
    bus_req_d   = bus_req_q;
    bus_util_d  = bus_util_q;
    rd_wrt_d    = rd_wrt_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    data_out_d  = data_out_q;
    tmo_d       = tmo_q;
    hist_d      = hist_q;
    sr_load     = 1'b0;
    sr_load_dat = '0;
    sr_shift    = 1'b0;
    go_done     = 1'b0;
    go_abort    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_in) begin
          sid_d     = slave_id_in;
          addr_d    = addr_in;
          wdat_d    = data_in;
          rw_lat_d  = rd_wrt_in;
          busy_d    = 1'b1;
          bus_req_d = 1'b1;
          state_d   = ST_WAIT_GRANT;
        end
      end
      ST_WAIT_GRANT: begin
        if (arbiter_grant) begin
          bus_util_d  = 1'b1;
          rd_wrt_d    = rw_lat_q;
          tmo_d       = '0;
          sr_load     = 1'b1;
          sr_load_dat = hdr_al;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        if (tmo_q == TMO_W'(START_LEN - 1)) state_d = ST_TX_SID;
        else                                 tmo_d   = tmo_q + TMO_W'(1);
      end
      ST_TX_SID: begin
        sr_shift = 1'b1;
        if (sr_cnt == SR_CNT_W'(SID_W - 1)) state_d = ST_TX_ADDR;
      end
      ST_TX_ADDR: begin
        sr_shift = 1'b1;
        if (sr_cnt == SR_CNT_W'(HDR_W - 1)) begin
          tmo_d   = '0;
          hist_d  = '1;
          state_d = ST_WAIT_ADDR_ACK;
        end
      end
      ST_WAIT_ADDR_ACK: begin
        hist_d = HIST_W'({hist_q, bus_s});
        tmo_d  = tmo_q + TMO_W'(1);
        if (addr_ack) begin
          if (rw_lat_q) begin
            sr_load     = 1'b1;
            sr_load_dat = dat_al;
            state_d     = ST_TX_DATA;
          end else begin
            bus_req_d = 1'b0;
            tmo_d     = '0;
            state_d   = ST_WAIT_RD_DATA;
          end
        end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
          go_abort = 1'b1;
        end
      end
      ST_TX_DATA: begin
        sr_shift = 1'b1;
        if (sr_cnt == SR_CNT_W'(DATA_WIDTH)) begin
          bus_req_d = 1'b0;
          tmo_d     = '0;
          hist_d    = '1;
          state_d   = ST_WAIT_WR_ACK;
        end
      end
      ST_WAIT_WR_ACK: begin
        hist_d = HIST_W'({hist_q, bus_s});
        tmo_d  = tmo_q + TMO_W'(1);
        if (wr_ack)                                 go_done  = 1'b1;
        else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) go_abort = 1'b1;
      end
      ST_WAIT_RD_DATA: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (!bus_s) begin
          sr_load     = 1'b1;
          sr_load_dat = '0;
          state_d     = ST_RX_DATA;
        end else if (tmo_q == TMO_W'(RD_TIMEOUT - 1)) begin
          go_abort = 1'b1;
        end
      end
      ST_RX_DATA: begin
        sr_shift = 1'b1;
        if (sr_cnt == SR_CNT_W'(DATA_WIDTH - 1)) begin
          data_out_d = DATA_WIDTH'({sr_par, bus_s});
          go_done    = 1'b1;
        end
      end
      ST_DONE, ST_ABORT: state_d = ST_IDLE;
      default:           state_d = ST_IDLE;
    endcase

    if (go_done || go_abort) begin
      busy_d     = 1'b0;
      bus_req_d  = 1'b0;
      bus_util_d = 1'b0;
      rd_wrt_d   = 1'b0;
      done_d     = go_done;
      error_d    = go_abort;
      state_d    = go_done ? ST_DONE : ST_ABORT;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      sid_q      <= '0;
      addr_q     <= '0;
      wdat_q     <= '0;
      rw_lat_q   <= 1'b0;
      busy_q     <= 1'b0;
      bus_req_q  <= 1'b0;
      bus_util_q <= 1'b0;
      rd_wrt_q   <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      data_out_q <= '0;
      tmo_q      <= '0;
      hist_q     <= '1;
    end else begin
      state_q    <= state_d;
      sid_q      <= sid_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      rw_lat_q   <= rw_lat_d;
      busy_q     <= busy_d;
      bus_req_q  <= bus_req_d;
      bus_util_q <= bus_util_d;
      rd_wrt_q   <= rd_wrt_d;
      done_q     <= done_d;
      error_q    <= error_d;
      data_out_q <= data_out_d;
      tmo_q      <= tmo_d;
      hist_q     <= hist_d;
    end
  end

  assign bus_req  = bus_req_q;
  assign bus_util = bus_util_q;
  assign rd_wrt   = rd_wrt_q;
  assign data_out = data_out_q;
  assign done     = done_q;
  assign error    = error_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master: a scoreboard of expected serial bits and read words,
// with a bench-side slave driving acks and read data on the pulled-up line.
`timescale 1ns/1ps
module tb_bus_master;

  localparam int AW     = 15;
  localparam int DW     = 8;
  localparam int ACK_TO = 16;
  localparam int RD_TO  = 255;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          req_in = 1'b0;
  logic          rd_wrt_in = 1'b0;
  logic [2:0]    slave_id_in = '0;
  logic [AW-1:0] addr_in = '0;
  logic [DW-1:0] data_in = '0;
  logic          arbiter_grant = 1'b0;
  logic          bus_req, bus_util, rd_wrt, done, error, busy;
  logic [DW-1:0] data_out;
  logic          slv_oe = 1'b0;
  logic          slv_do = 1'b1;
  wire           data_bus_serial;

  assign data_bus_serial = slv_oe ? slv_do : 1'bz;
  pullup (data_bus_serial);

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int overlap = 0;
  logic          bit_q[$];
  logic [DW-1:0] rd_q[$];

  bus_master #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .ACK_TIMEOUT   (ACK_TO),
    .RD_TIMEOUT    (RD_TO)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .req_in          (req_in),
    .rd_wrt_in       (rd_wrt_in),
    .slave_id_in     (slave_id_in),
    .addr_in         (addr_in),
    .data_in         (data_in),
    .arbiter_grant   (arbiter_grant),
    .bus_req         (bus_req),
    .bus_util        (bus_util),
    .rd_wrt          (rd_wrt),
    .data_out        (data_out),
    .done            (done),
    .error           (error),
    .busy            (busy),
    .data_bus_serial (data_bus_serial)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done)          done_cnt <= done_cnt + 1;
    if (error)         err_cnt  <= err_cnt + 1;
    if (done && error) overlap  <= overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_hdr(input logic [2:0] sid, input logic [AW-1:0] a);
    bit_q.push_back(1'b0);
    bit_q.push_back(1'b0);
    for (int i = 2; i >= 0; i--) bit_q.push_back(sid[i]);
    for (int i = AW - 1; i >= 0; i--) bit_q.push_back(a[i]);
  endtask

  task automatic push_dat(input logic [DW-1:0] d);
    bit_q.push_back(1'b1);
    for (int i = DW - 1; i >= 0; i--) bit_q.push_back(d[i]);
  endtask

  // Issues a request, scrambles the inputs after acceptance, and grants the bus.
  task automatic request(input logic rw, input logic [2:0] sid, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    @(negedge clk);
    req_in = 1'b1; rd_wrt_in = rw; slave_id_in = sid; addr_in = a; data_in = d;
    @(negedge clk);
    req_in = 1'b0; rd_wrt_in = ~rw; slave_id_in = ~sid; addr_in = ~a; data_in = ~d;
    check("busy_set", busy, 1);
    check("bus_req_set", bus_req, 1);
    check("util_pre_grant", bus_util, 0);
    arbiter_grant = 1'b1;
    @(negedge clk);
    check("bus_util_set", bus_util, 1);
    check("rd_wrt_drv", rd_wrt, rw);
  endtask

  // Compares n driven bits against the scoreboard, one per cycle.
  task automatic drain(input int n, input string tag, input int pulse_at);
    logic e;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      e = bit_q.pop_front();
      check(tag, data_bus_serial, e);
      arbiter_grant = 1'b0;
      if (i == pulse_at) begin
        req_in = 1'b1; rd_wrt_in = 1'b0; addr_in = 15'h0F0F;
      end else begin
        req_in = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_write(input logic [2:0] sid, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit glitch, input int pulse_at);
    push_hdr(sid, a);
    push_dat(d);
    request(1'b1, sid, a, d);
    drain(5 + AW, "wr_hdr_bit", -1);
    slv_oe = 1'b1; slv_do = 1'b0;
    #1 check("wr_addr_released", data_bus_serial, 0);
    if (glitch) begin
      @(negedge clk); slv_do = 1'b1;
      @(negedge clk); slv_do = 1'b0;
      #1 check("glitch_no_ack", data_bus_serial, 0);
    end
    @(negedge clk);
    @(negedge clk); slv_oe = 1'b0;
    drain(DW + 1, "wr_data_bit", pulse_at);
    check("wr_bus_req_drop", bus_req, 0);
    check("wr_busy_hold", busy, 1);
    slv_oe = 1'b1; slv_do = 1'b0;
    @(negedge clk); slv_do = 1'b1;
    @(negedge clk); slv_oe = 1'b0;
    check("wr_done", done, 1);
    check("wr_flags_clr", {busy, bus_util, rd_wrt, error}, 4'b0000);
    @(negedge clk);
    check("wr_done_width", done, 0);
    @(negedge clk);
    check("wr_idle_after", {busy, bus_req}, 2'b00);
  endtask

  task automatic do_read(input logic [2:0] sid, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] exp_d;
    push_hdr(sid, a);
    rd_q.push_back(d);
    request(1'b0, sid, a, 8'h00);
    drain(5 + AW, "rd_hdr_bit", -1);
    slv_oe = 1'b1; slv_do = 1'b0;
    #1 check("rd_addr_released", data_bus_serial, 0);
    @(negedge clk);
    @(negedge clk);
    check("rd_bus_req_drop", bus_req, 0);
    check("rd_busy_hold", busy, 1);
    slv_do = 1'b1;
    @(negedge clk); slv_do = 1'b0;
    for (int i = DW - 1; i >= 0; i--) begin
      @(negedge clk); slv_do = d[i];
    end
    @(negedge clk); slv_oe = 1'b0;
    exp_d = rd_q.pop_front();
    check("rd_done", done, 1);
    check("rd_data_out", data_out, exp_d);
    check("rd_flags_clr", {busy, bus_util, rd_wrt, error}, 4'b0000);
    @(negedge clk);
    check("rd_done_width", done, 0);
    check("rd_data_hold", data_out, exp_d);
  endtask

  initial begin
    int n;
    int d0, e0;

    #12;
    check("rst_outputs", {bus_req, bus_util, rd_wrt, done, error, busy}, 6'b0);
    check("rst_data_out", data_out, 0);
    check("rst_bus_released", data_bus_serial, 1);
    @(negedge clk); rstn = 1'b1;

    do_write(3'b010, 15'h1234, 8'hA5, 1'b0, -1);
    do_read(3'b011, 15'h0007, 8'h3C);

    // No address acknowledge: abort after the timeout.
    push_hdr(3'b101, 15'h4321);
    request(1'b1, 3'b101, 15'h4321, 8'h77);
    drain(5 + AW, "to_hdr_bit", -1);
    n = 0;
    while (!error && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles", n, ACK_TO);
    check("to_error", error, 1);
    check("to_flags_clr", {busy, bus_util, bus_req, rd_wrt, done}, 5'b0);
    check("to_data_out_kept", data_out, 8'h3C);
    slv_oe = 1'b1; slv_do = 1'b0;
    #1 check("to_bus_released", data_bus_serial, 0);
    @(negedge clk); slv_oe = 1'b0;
    check("to_error_width", error, 0);

    // Glitched ack plus a stray request mid-data.
    do_write(3'b001, 15'h2AAA, 8'h5A, 1'b1, 3);

    // Reset during the address phase.
    push_hdr(3'b110, 15'h1111);
    request(1'b1, 3'b110, 15'h1111, 8'hC3);
    drain(10, "rst_hdr_bit", -1);
    bit_q.delete();
    d0 = done_cnt; e0 = err_cnt;
    rstn = 1'b0;
    slv_oe = 1'b1; slv_do = 1'b0;
    #1 check("rst_mid_bus_released", data_bus_serial, 0);
    check("rst_mid_outputs", {bus_req, bus_util, rd_wrt, done, error, busy}, 6'b0);
    check("rst_mid_data_out", data_out, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1; slv_oe = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_no_done", done_cnt - d0, 0);
    check("rst_mid_no_error", err_cnt - e0, 0);
    do_read(3'b100, 15'h7F00, 8'h81);

    repeat (2) @(negedge clk);
    check("done_total", done_cnt, 4);
    check("error_total", err_cnt, 1);
    check("done_error_overlap", overlap, 0);
    check("sb_empty", bit_q.size() + rd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
